// File: rtl/uart_rx_deserializer_if.sv
// Receive-side bundle between the raw serial line, the deserializer and the
// holding register that consumes Rx_Data.
interface uart_rx_deserializer_if #(
    parameter int unsigned WORD_LENGTH = 8
);
    logic                   Serial_In;
    logic [WORD_LENGTH-1:0] Rx_Data;
    logic                   Rx_Valid;
    logic                   Parity_Error;
    logic                   Framing_Error;
    logic                   Busy;

    modport master (
        input  Serial_In,
        output Rx_Data,
        output Rx_Valid,
        output Parity_Error,
        output Framing_Error,
        output Busy
    );

    modport slave (
        output Serial_In,
        input  Rx_Data,
        input  Rx_Valid,
        input  Parity_Error,
        input  Framing_Error,
        input  Busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronises the RX line, finds the start bit, samples each
// bit at mid-period, checks optional parity and the stop bit, and pulses the result.
module uart_rx_deserializer #(
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned BIT_TICKS   = 434,
    parameter bit          PARITY_EN   = 1'b0,
    parameter bit          PARITY_ODD  = 1'b0
) (
    input logic                    clk,
    input logic                    reset,
    uart_rx_deserializer_if.master rx_bus
);
    localparam int unsigned TickW = $clog2(BIT_TICKS);
    localparam int unsigned BitW  = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(BIT_TICKS - 1);
    localparam logic [TickW-1:0] TickHalf = TickW'(BIT_TICKS / 2 - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(WORD_LENGTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone,
        StWaitIdle
    } state_e;

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [TickW-1:0]       tick_q, tick_d;
    logic [BitW-1:0]        bit_q, bit_d;
    logic [WORD_LENGTH-1:0] shift_q, shift_d;
    logic [WORD_LENGTH-1:0] data_q, data_d;
    logic                   par_err_q, par_err_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   tick_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_bus.Serial_In;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            par_err_q <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            par_err_q <= par_err_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q + TickW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        par_err_d = par_err_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        tick_end  = (tick_q == TickLast);

        unique case (state_q)
            StIdle: begin
                tick_d = '0;
                if (!rx_s_q) begin
                    state_d   = StStart;
                    par_err_d = 1'b0;
                end
            end
            StStart: begin
                if (tick_q == TickHalf) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? StIdle : StData;
                end
            end
            StData: begin
                if (tick_end) begin
                    tick_d  = '0;
                    // Shift in from the MSB end so the first (LSB) bit lands in bit 0.
                    shift_d = WORD_LENGTH'({rx_s_q, shift_q} >> 1);
                    if (bit_q == BitLast) begin
                        state_d = PARITY_EN ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            StParity: begin
                if (tick_end) begin
                    tick_d    = '0;
                    par_err_d = PARITY_EN && (((^shift_q) ^ rx_s_q) != PARITY_ODD);
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (tick_end) begin
                    tick_d = '0;
                    // Outputs load on entry so they are visible during the DONE cycle.
                    if (rx_s_q) begin
                        state_d = StDone;
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        perr_d  = par_err_q;
                    end else begin
                        state_d = StWaitIdle;
                        ferr_d  = 1'b1;
                    end
                end
            end
            StDone: begin
                tick_d  = '0;
                state_d = StIdle;
            end
            StWaitIdle: begin
                tick_d = '0;
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                tick_d  = '0;
                state_d = StIdle;
            end
        endcase
    end

    assign rx_bus.Rx_Data       = data_q;
    assign rx_bus.Rx_Valid      = valid_q;
    assign rx_bus.Parity_Error  = perr_q;
    assign rx_bus.Framing_Error = ferr_q;
    assign rx_bus.Busy          = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: one receiver without parity, one with even parity,
// both at 8 clocks per bit, fed whole frames and checked against expected outcomes.
module tb_uart_rx_deserializer;
    localparam int unsigned W  = 8;
    localparam int unsigned BT = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   fa_cnt       = 0;
    int   busy_a_cnt   = 0;
    int   stray_cnt    = 0;
    logic [W-1:0] last_a = '0;

    always #5 clk = ~clk;

    uart_rx_deserializer_if #(.WORD_LENGTH(W)) bus_a ();
    uart_rx_deserializer_if #(.WORD_LENGTH(W)) bus_b ();

    uart_rx_deserializer #(
        .WORD_LENGTH(W), .BIT_TICKS(BT), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
    ) dut_a (
        .clk(clk), .reset(reset), .rx_bus(bus_a)
    );

    uart_rx_deserializer #(
        .WORD_LENGTH(W), .BIT_TICKS(BT), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .rx_bus(bus_b)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         perr;
        int           cyc;
    } ev_t;

    ev_t va_q[$];
    ev_t vb_q[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus_a.Rx_Valid === 1'b1)
            va_q.push_back('{data: bus_a.Rx_Data, perr: bus_a.Parity_Error, cyc: cyc});
        if (bus_b.Rx_Valid === 1'b1)
            vb_q.push_back('{data: bus_b.Rx_Data, perr: bus_b.Parity_Error, cyc: cyc});
        if (bus_a.Framing_Error === 1'b1) fa_cnt++;
        if (bus_a.Busy === 1'b1) busy_a_cnt++;
        if (bus_a.Parity_Error === 1'b1) stray_cnt++;
        if (bus_b.Parity_Error === 1'b1 && bus_b.Rx_Valid !== 1'b1) stray_cnt++;
        if (bus_b.Framing_Error === 1'b1) stray_cnt++;
        if (bus_a.Rx_Valid === 1'b1 && bus_a.Framing_Error === 1'b1) stray_cnt++;
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input bit b, input logic lvl);
        if (b) bus_b.Serial_In = lvl;
        else   bus_a.Serial_In = lvl;
    endtask

    // Whole frame on the line; the line is left at the stop level afterwards.
    task automatic send_frame(input bit b, input logic [W-1:0] data, input logic pbit,
                              input logic stop_lvl);
        set_line(b, 1'b0);
        hold(BT);
        for (int i = 0; i < W; i++) begin
            set_line(b, data[i]);
            hold(BT);
        end
        if (b) begin
            set_line(b, pbit);
            hold(BT);
        end
        set_line(b, stop_lvl);
        hold(BT);
    endtask

    task automatic test_reset();
        set_line(1'b0, 1'b1);
        set_line(1'b1, 1'b1);
        hold(3);
        tests_run += 6;
        if (bus_a.Rx_Data !== '0) begin
            tests_failed++; $display("FAIL reset_data: got %h expected 00", bus_a.Rx_Data);
        end
        if (bus_a.Rx_Valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus_a.Rx_Valid);
        end
        if (bus_a.Parity_Error !== 1'b0) begin
            tests_failed++; $display("FAIL reset_perr: got %b expected 0", bus_a.Parity_Error);
        end
        if (bus_a.Framing_Error !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ferr: got %b expected 0", bus_a.Framing_Error);
        end
        if (bus_a.Busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_busy_a: got %b expected 0", bus_a.Busy);
        end
        if (bus_b.Busy !== 1'b0 || bus_b.Rx_Data !== '0) begin
            tests_failed++;
            $display("FAIL reset_b: got busy %b data %h expected 0/00", bus_b.Busy, bus_b.Rx_Data);
        end
        reset = 1'b1;
        hold(5);
    endtask

    task automatic test_single_frame();
        int base = va_q.size();
        int f0   = fa_cnt;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
        hold(6);
        tests_run += 3;
        if (va_q.size() - base != 1) begin
            tests_failed++; $display("FAIL single_count: got %0d expected 1", va_q.size() - base);
        end else if (va_q[base].data !== 8'hA5 || va_q[base].perr !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_data: got %h/%b expected a5/0", va_q[base].data, va_q[base].perr);
        end
        if (fa_cnt != f0) begin
            tests_failed++; $display("FAIL single_ferr: got %0d expected 0", fa_cnt - f0);
        end
        if (bus_a.Busy !== 1'b0) begin
            tests_failed++; $display("FAIL single_busy: got %b expected 0", bus_a.Busy);
        end
        last_a = 8'hA5;
    endtask

    task automatic test_back_to_back();
        int base = va_q.size();
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b1);
        hold(6);
        tests_run++;
        if (va_q.size() - base != 2) begin
            tests_failed++; $display("FAIL b2b_count: got %0d expected 2", va_q.size() - base);
        end else begin
            tests_run += 3;
            if (va_q[base].data !== 8'h3C) begin
                tests_failed++; $display("FAIL b2b_first: got %h expected 3c", va_q[base].data);
            end
            if (va_q[base+1].data !== 8'hFF) begin
                tests_failed++; $display("FAIL b2b_second: got %h expected ff", va_q[base+1].data);
            end
            if (va_q[base+1].cyc - va_q[base].cyc != 10 * BT) begin
                tests_failed++;
                $display("FAIL b2b_spacing: got %0d expected %0d",
                         va_q[base+1].cyc - va_q[base].cyc, 10 * BT);
            end
        end
        last_a = 8'hFF;
    endtask

    task automatic test_glitch();
        int base  = va_q.size();
        int busy0 = busy_a_cnt;
        set_line(1'b0, 1'b0);
        hold(2);
        set_line(1'b0, 1'b1);
        hold(20);
        tests_run += 3;
        if (va_q.size() != base) begin
            tests_failed++; $display("FAIL glitch_valid: got %0d expected 0", va_q.size() - base);
        end
        if (busy_a_cnt - busy0 != BT / 2) begin
            tests_failed++;
            $display("FAIL glitch_busy: got %0d expected %0d", busy_a_cnt - busy0, BT / 2);
        end
        if (bus_a.Rx_Data !== last_a) begin
            tests_failed++; $display("FAIL glitch_data: got %h expected %h", bus_a.Rx_Data, last_a);
        end
    endtask

    task automatic test_framing();
        int base = va_q.size();
        int f0   = fa_cnt;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0);
        hold(2 * BT);
        tests_run += 5;
        if (bus_a.Busy !== 1'b1) begin
            tests_failed++; $display("FAIL frame_busy_low: got %b expected 1", bus_a.Busy);
        end
        set_line(1'b0, 1'b1);
        hold(5);
        if (bus_a.Busy !== 1'b0) begin
            tests_failed++; $display("FAIL frame_busy_high: got %b expected 0", bus_a.Busy);
        end
        if (fa_cnt - f0 != 1) begin
            tests_failed++; $display("FAIL frame_ferr: got %0d expected 1", fa_cnt - f0);
        end
        if (va_q.size() != base) begin
            tests_failed++; $display("FAIL frame_valid: got %0d expected 0", va_q.size() - base);
        end
        if (bus_a.Rx_Data !== last_a) begin
            tests_failed++; $display("FAIL frame_data: got %h expected %h", bus_a.Rx_Data, last_a);
        end
    endtask

    task automatic test_parity();
        logic pbits[2] = '{1'b0, 1'b1};
        logic experr[2] = '{1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            int base = vb_q.size();
            send_frame(1'b1, 8'h07, pbits[k], 1'b1);
            hold(6);
            tests_run++;
            if (vb_q.size() - base != 1) begin
                tests_failed++;
                $display("FAIL parity_count%0d: got %0d expected 1", k, vb_q.size() - base);
            end else begin
                tests_run += 2;
                if (vb_q[base].data !== 8'h07) begin
                    tests_failed++;
                    $display("FAIL parity_data%0d: got %h expected 07", k, vb_q[base].data);
                end
                if (vb_q[base].perr !== experr[k]) begin
                    tests_failed++;
                    $display("FAIL parity_flag%0d: got %b expected %b", k, vb_q[base].perr,
                             experr[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int base = va_q.size();
        int f0   = fa_cnt;
        // Bits 4..7 and stop are high, so the tail after release looks like idle line.
        fork
            send_frame(1'b0, 8'hF0, 1'b0, 1'b1);
            begin
                hold(5 * BT + 3);
                reset = 1'b0;
                #1;
                tests_run++;
                if (bus_a.Rx_Data !== '0 || bus_a.Rx_Valid !== 1'b0 || bus_a.Busy !== 1'b0 ||
                    bus_a.Parity_Error !== 1'b0 || bus_a.Framing_Error !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL midreset_outputs: got data %h valid %b busy %b expected 0",
                             bus_a.Rx_Data, bus_a.Rx_Valid, bus_a.Busy);
                end
                hold(2);
                reset = 1'b1;
            end
        join
        hold(10);
        tests_run += 3;
        if (va_q.size() != base || fa_cnt != f0) begin
            tests_failed++;
            $display("FAIL midreset_tail: got %0d valid %0d ferr expected 0/0",
                     va_q.size() - base, fa_cnt - f0);
        end
        base = va_q.size();
        send_frame(1'b0, 8'h81, 1'b0, 1'b1);
        hold(6);
        if (va_q.size() - base != 1) begin
            tests_failed++; $display("FAIL midreset_count: got %0d expected 1", va_q.size() - base);
        end
        if (bus_a.Rx_Data !== 8'h81) begin
            tests_failed++; $display("FAIL midreset_data: got %h expected 81", bus_a.Rx_Data);
        end
        last_a = 8'h81;
    endtask

    task automatic test_random_plain();
        for (int n = 0; n < 16; n++) begin
            logic [W-1:0] d    = W'($urandom);
            logic         good = ($urandom_range(0, 3) != 0);
            int           base = va_q.size();
            int           f0   = fa_cnt;
            send_frame(1'b0, d, 1'b0, good);
            if (!good) begin
                hold(BT);
                set_line(1'b0, 1'b1);
            end
            hold($urandom_range(4, 10));
            if (good) last_a = d;
            tests_run += 3;
            if (va_q.size() - base != (good ? 1 : 0)) begin
                tests_failed++;
                $display("FAIL rand_a_valid%0d: got %0d expected %0d", n, va_q.size() - base,
                         good ? 1 : 0);
            end
            if (fa_cnt - f0 != (good ? 0 : 1)) begin
                tests_failed++;
                $display("FAIL rand_a_ferr%0d: got %0d expected %0d", n, fa_cnt - f0,
                         good ? 0 : 1);
            end
            if (bus_a.Rx_Data !== last_a) begin
                tests_failed++;
                $display("FAIL rand_a_data%0d: got %h expected %h", n, bus_a.Rx_Data, last_a);
            end
        end
    endtask

    task automatic test_random_parity();
        for (int n = 0; n < 16; n++) begin
            logic [W-1:0] d    = W'($urandom);
            logic         pbit = 1'($urandom_range(0, 1));
            // Even parity: an odd count of ones across data and parity bit is an error.
            logic         experr = ($countones({d, pbit}) % 2) == 1;
            int           base = vb_q.size();
            send_frame(1'b1, d, pbit, 1'b1);
            hold($urandom_range(4, 10));
            tests_run++;
            if (vb_q.size() - base != 1) begin
                tests_failed++;
                $display("FAIL rand_b_count%0d: got %0d expected 1", n, vb_q.size() - base);
            end else if (vb_q[base].data !== d || vb_q[base].perr !== experr) begin
                tests_failed++;
                $display("FAIL rand_b_frame%0d: got %h/%b expected %h/%b", n, vb_q[base].data,
                         vb_q[base].perr, d, experr);
            end
        end
    endtask

    initial begin
        bus_a.Serial_In = 1'b1;
        bus_b.Serial_In = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_parity();
        test_reset_mid_frame();
        test_random_plain();
        test_random_parity();
        tests_run++;
        if (stray_cnt != 0) begin
            tests_failed++; $display("FAIL stray_pulses: got %0d expected 0", stray_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
